hpb_cfg_tx: RTL and testbench
=============================

HPB_CFG_TX -- requirements
Module: hpb_cfg_tx

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, word depth of the host write buffer (power of two, 2..16).
REQ-002 Parameter TIMEOUT_CYCLES, default 1024, maximum cycles cfg_valid is held without cfg_accept; 0 disables the timeout.
REQ-003 clk  input  1  core clock; all logic single clock domain.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 wr_valid  input  1  host write request.
REQ-006 wr_data  input  CFG_DATA_W  host config word.
REQ-007 wr_ready  output  1  buffer can take a word this cycle.
REQ-008 flush  input  1  discard all buffered and in-flight words.
REQ-009 err_clear  input  1  clears timeout_err and drop_count.
REQ-010 in_config_valid  output  1  config word presented to the core host interface.
REQ-011 in_config_data  output  CFG_DATA_W  config word.
REQ-012 in_config_accept  input  1  core takes the word.
REQ-013 fifo_level  output  $clog2(FIFO_DEPTH)+1  buffered words, excluding the word being driven.
REQ-014 sent_count  output  16  accepted words, wrapping modulo 2^16.
REQ-015 drop_count  output  8  timed-out words, saturating at 255.
REQ-016 timeout_err  output  1  sticky, set on any timeout drop.

Function
REQ-017 A host write occurs when wr_valid and wr_ready are both high at a clk edge; wr_ready = (fifo_level < FIFO_DEPTH) and not flush, combinational.
REQ-018 FSM states are IDLE and DRIVE; in IDLE, in_config_valid is low.
REQ-019 IDLE -> DRIVE when the FIFO is non-empty; the head word is popped into the output register and in_config_valid is high from the next cycle.
REQ-020 A write into an empty FIFO while in IDLE at edge N produces in_config_valid high after edge N+1; there is no bypass path.
REQ-021 In DRIVE, in_config_valid and in_config_data are held stable until the accept or drop edge.
REQ-022 A transfer occurs when in_config_valid and in_config_accept are both high; sent_count then increments.
REQ-023 On transfer with a non-empty FIFO, the next word loads in the same edge and in_config_valid stays high: one word per cycle is sustained.
REQ-024 On transfer with an empty FIFO, the FSM returns to IDLE and in_config_valid goes low.
REQ-025 The wait counter clears on every load into the output register and increments each DRIVE cycle without accept.
REQ-026 When TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES-1 with no accept, the word is dropped at that edge: drop_count +1 (saturating), timeout_err set, next word loaded or IDLE.
REQ-027 Accept on the same cycle as the timeout limit counts as a transfer, not a drop.
REQ-028 A simultaneous host write and pop leave fifo_level unchanged; the FIFO read and write pointers wrap modulo FIFO_DEPTH.
REQ-029 flush empties the FIFO, forces IDLE and in_config_valid low at the next edge, and does not change the counters; flush overrides accept, timeout and write in the same cycle.
REQ-030 err_clear zeroes drop_count and timeout_err; a drop in the same cycle wins, leaving drop_count=1 and timeout_err=1.

Reset
REQ-031 reset asynchronously forces IDLE, empty FIFO, in_config_valid=0, in_config_data=0, fifo_level=0, sent_count=0, drop_count=0, timeout_err=0, wait counter=0.
REQ-032 Reset mid-DRIVE discards the in-flight word with no count update; wr_ready is high in the first cycle after reset deassertion.

Structure
REQ-033 CFG_DATA_W and the FSM state enum typedef live in tts_pkg; the FIFO storage is plain registers.
REQ-034 The buffer is one sub-module, hpb_cfg_fifo (synchronous FIFO with level output); the FSM, timeout logic and counters live in hpb_cfg_tx.

Verification
REQ-035 Single word 0xA5 with accept held high -> in_config_valid high one cycle after the write, data 0xA5, sent_count=1, back to IDLE.
REQ-036 Five back-to-back writes, accept low -> wr_ready low after the fifth write (4 in FIFO plus 1 driving); raise accept -> five transfers on consecutive cycles in order, sent_count=5.
REQ-037 TIMEOUT_CYCLES=8, accept never asserted -> word dropped after 8 valid cycles, drop_count=1, timeout_err=1; accept on cycle 8 instead -> transfer, drop_count=0.
REQ-038 Three words buffered and driving, pulse flush -> in_config_valid low next cycle, fifo_level=0, sent_count unchanged.
REQ-039 Assert reset mid-DRIVE with 2 words queued -> all outputs zero immediately; after release a new write is sent normally.
REQ-040 Write and accept every cycle for 40 words -> pointer wrap, fifo_level stable, data order preserved, sent_count=40.

Source files
------------

// File: rtl/tts_pkg.sv
// Shared definitions for the host-to-core configuration transmit path:
// word width, transmit FSM encoding and small counter helpers.
package tts_pkg;

    // Width of one configuration word on both the host and core sides.
    localparam int CFG_DATA_W = 32;

    // Legacy-compatible state codes; the enum below is built on them so
    // debug tooling that decodes the raw bit keeps working.
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_DRIVE = 1'b1;

    typedef enum logic [0:0] {
        IDLE  = ST_IDLE,
        DRIVE = ST_DRIVE
    } tx_state_e;

    // Width of the drop counter and its saturation value.
    localparam int          DROP_W   = 8;
    localparam logic [7:0]  DROP_MAX = 8'hFF;

    // Saturating increment for the drop counter.
    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (v == DROP_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/hpb_cfg_fifo.sv
// Synchronous word FIFO with a level output. Storage is a plain register
// array; pointers are power-of-two sized so they wrap naturally.
// clear empties the FIFO at the next edge and wins over push/pop.
module hpb_cfg_fifo
    import tts_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = CFG_DATA_W,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic [W-1:0]     push_data,
    input  logic             pop,
    output logic [W-1:0]     head_data,
    output logic             empty,
    output logic             full,
    output logic [LVL_W-1:0] level
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    // Illegal requests (push when full, pop when empty) are ignored.
    always_comb begin
        empty   = (level == '0);
        full    = (level == LVL_W'(DEPTH));
        push_ok = push && !full && !clear;
        pop_ok  = pop && !empty && !clear;
    end

    assign head_data = mem[rd_ptr];

    // Pointer and level bookkeeping; a simultaneous push and pop keeps level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Word storage; contents need no reset because level gates every read.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/hpb_cfg_tx.sv
// Buffers host configuration writes and presents them one at a time to the
// core's config interface, with a per-word accept timeout, flush, and
// sent/drop bookkeeping.
//
// Handshakes (both sides): a word moves on a clk edge where its valid and
// ready/accept are both high. wr_ready is combinational from the FIFO level
// and flush; in_config_valid/in_config_data are registered and held stable
// until the edge that accepts or drops the word.
module hpb_cfg_tx
    import tts_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            wr_valid,
    input  logic [CFG_DATA_W-1:0]           wr_data,
    output logic                            wr_ready,
    input  logic                            flush,
    input  logic                            err_clear,
    output logic                            in_config_valid,
    output logic [CFG_DATA_W-1:0]           in_config_data,
    input  logic                            in_config_accept,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic [15:0]                     sent_count,
    output logic [7:0]                      drop_count,
    output logic                            timeout_err,
    output logic [0:0]                      dbg_state
);

    localparam int LVL_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT_CYCLES - 1);

    tx_state_e             state;
    logic [WAIT_W-1:0]     wait_cnt;
    logic [CFG_DATA_W-1:0] fifo_head;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  wr_fire;
    logic                  xfer;
    logic                  timeout_hit;
    logic                  slot_free;
    logic                  load;

    // Handshake decode and output-slot bookkeeping.
    always_comb begin
        wr_ready    = !fifo_full && !flush;
        wr_fire     = wr_valid && wr_ready;
        xfer        = (state == DRIVE) && in_config_accept;
        // An accept on the limit cycle is a transfer, never a drop.
        timeout_hit = TMO_EN && (state == DRIVE) && !in_config_accept
                      && (wait_cnt == WAIT_LIMIT);
        // The output register can take a new word when idle or when the
        // current word leaves this edge.
        slot_free   = (state == IDLE) || xfer || timeout_hit;
        load        = slot_free && !fifo_empty && !flush;
    end

    assign in_config_valid = (state == DRIVE);
    assign dbg_state       = state;

    hpb_cfg_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (CFG_DATA_W),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (flush),
        .push      (wr_fire),
        .push_data (wr_data),
        .pop       (load),
        .head_data (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .level     (fifo_level)
    );

    // Transmit FSM, output word register and accept wait counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            in_config_data <= '0;
            wait_cnt       <= '0;
        end else if (flush) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else if (load) begin
            state          <= DRIVE;
            in_config_data <= fifo_head;
            wait_cnt       <= '0;
        end else if (xfer || timeout_hit) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else if (state == DRIVE) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Sent counter; wraps, and a flush cancels the transfer in its cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sent_count <= '0;
        end else if (xfer && !flush) begin
            sent_count <= sent_count + 16'd1;
        end
    end

    // Drop counter and sticky error; a drop beats a same-cycle err_clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_count  <= '0;
            timeout_err <= 1'b0;
        end else if (timeout_hit && !flush) begin
            drop_count  <= err_clear ? 8'd1 : sat_inc(drop_count);
            timeout_err <= 1'b1;
        end else if (err_clear) begin
            drop_count  <= '0;
            timeout_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_hpb_cfg_tx.sv
// Directed + randomized bench for hpb_cfg_tx, checked against a queue-based
// transaction model of the host buffer and output slot.
module tb_hpb_cfg_tx;

    localparam int DEPTH = 4;
    localparam int TMO   = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        wr_valid = 1'b0;
    logic [31:0] wr_data = '0;
    logic        wr_ready;
    logic        flush = 1'b0;
    logic        err_clear = 1'b0;
    logic        in_config_valid;
    logic [31:0] in_config_data;
    logic        in_config_accept = 1'b0;
    logic [2:0]  fifo_level;
    logic [15:0] sent_count;
    logic [7:0]  drop_count;
    logic        timeout_err;
    logic [0:0]  dbg_state;

    hpb_cfg_tx #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk              (clk),
        .reset            (reset),
        .wr_valid         (wr_valid),
        .wr_data          (wr_data),
        .wr_ready         (wr_ready),
        .flush            (flush),
        .err_clear        (err_clear),
        .in_config_valid  (in_config_valid),
        .in_config_data   (in_config_data),
        .in_config_accept (in_config_accept),
        .fifo_level       (fifo_level),
        .sent_count       (sent_count),
        .drop_count       (drop_count),
        .timeout_err      (timeout_err),
        .dbg_state        (dbg_state)
    );

    // ---------------- reference model ----------------
    logic [31:0] exp_q[$];     // words waiting in the host buffer
    bit          m_valid;      // a word is on the core interface
    logic [31:0] m_data;
    int          m_wait;       // cycles the current word has waited
    logic [15:0] m_sent;
    logic [7:0]  m_drop;
    bit          m_err;

    int n_pass = 0;
    int n_total = 0;

    task automatic model_reset();
        exp_q.delete();
        m_valid = 0; m_data = '0; m_wait = 0;
        m_sent = '0; m_drop = '0; m_err = 0;
    endtask

    // Apply one clock edge worth of rules to the model, using current inputs.
    task automatic model_edge();
        bit wr_ok, xfer, drop;
        wr_ok = wr_valid && (exp_q.size() < DEPTH) && !flush;
        if (flush) begin
            exp_q.delete();
            m_valid = 0;
            m_wait  = 0;
            if (err_clear) begin m_drop = '0; m_err = 0; end
        end else begin
            xfer = m_valid && in_config_accept;
            drop = m_valid && !in_config_accept && (m_wait == TMO - 1);
            if (xfer) m_sent = m_sent + 16'd1;
            if (drop) begin
                m_drop = err_clear ? 8'd1 : ((m_drop == 8'd255) ? 8'd255 : m_drop + 8'd1);
                m_err  = 1;
            end else if (err_clear) begin
                m_drop = '0; m_err = 0;
            end
            if ((!m_valid || xfer || drop) && exp_q.size() > 0) begin
                m_data  = exp_q.pop_front();
                m_valid = 1;
                m_wait  = 0;
            end else if (xfer || drop) begin
                m_valid = 0;
            end else if (m_valid) begin
                m_wait++;
            end
            if (wr_ok) exp_q.push_back(wr_data);
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic check_all();
        chk("valid", 32'(in_config_valid), 32'(m_valid));
        chk("state", 32'(dbg_state), 32'(m_valid));
        if (m_valid) chk("data", in_config_data, m_data);
        chk("level", 32'(fifo_level), 32'(exp_q.size()));
        chk("sent", 32'(sent_count), 32'(m_sent));
        chk("drop", 32'(drop_count), 32'(m_drop));
        chk("err", 32'(timeout_err), 32'(m_err));
    endtask

    // ---------------- driver tasks ----------------
    // One cycle: check wr_ready before the edge, advance model, check after.
    task automatic step();
        #1;
        chk("wr_ready", 32'(wr_ready), 32'((exp_q.size() < DEPTH) && !flush));
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        wr_valid = 0; flush = 0; err_clear = 0;
    endtask

    task automatic write_word(input logic [31:0] d);
        wr_valid = 1; wr_data = d;
        step();
        wr_valid = 0;
    endtask

    // Safety net so the run can never hang.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    logic [15:0] saved_sent;

    initial begin
        // ---------------- reset state ----------------
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(in_config_valid), 32'd0);
        chk("rst_data", in_config_data, 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_sent", 32'(sent_count), 32'd0);
        chk("rst_drop", 32'(drop_count), 32'd0);
        chk("rst_err", 32'(timeout_err), 32'd0);
        reset = 0;

        // ---------------- single word, accept held ----------------
        in_config_accept = 1;
        write_word(32'hA5);
        chk("single_valid_pre", 32'(in_config_valid), 32'd0);
        step();
        chk("single_valid", 32'(in_config_valid), 32'd1);
        chk("single_data", in_config_data, 32'hA5);
        step();
        chk("single_sent", 32'(sent_count), 32'd1);
        chk("single_idle", 32'(in_config_valid), 32'd0);

        // ---------------- fill buffer, then drain ----------------
        in_config_accept = 0;
        for (int i = 0; i < 5; i++) write_word($urandom);
        #1;
        chk("full_ready", 32'(wr_ready), 32'd0);
        chk("full_level", 32'(fifo_level), 32'd4);
        in_config_accept = 1;
        for (int i = 0; i < 6; i++) step();
        chk("drain_sent", 32'(sent_count), 32'd6);

        // ---------------- timeout drop ----------------
        in_config_accept = 0;
        write_word($urandom);
        step();                              // word loaded
        for (int i = 0; i < TMO; i++) step();
        chk("tmo_valid", 32'(in_config_valid), 32'd0);
        chk("tmo_drop", 32'(drop_count), 32'd1);
        chk("tmo_err", 32'(timeout_err), 32'd1);
        err_clear = 1; step(); err_clear = 0;
        chk("clr_drop", 32'(drop_count), 32'd0);
        chk("clr_err", 32'(timeout_err), 32'd0);

        // accept on the limit cycle is a transfer
        write_word($urandom);
        step();
        for (int i = 0; i < TMO - 1; i++) step();
        in_config_accept = 1; step(); in_config_accept = 0;
        chk("limit_drop", 32'(drop_count), 32'd0);
        chk("limit_sent", 32'(sent_count), 32'd7);

        // drop beats a same-cycle err_clear
        write_word($urandom);
        step();
        for (int i = 0; i < TMO - 1; i++) step();
        err_clear = 1; step(); err_clear = 0;
        chk("race_drop", 32'(drop_count), 32'd1);
        chk("race_err", 32'(timeout_err), 32'd1);
        err_clear = 1; step(); err_clear = 0;

        // ---------------- flush while driving ----------------
        for (int i = 0; i < 4; i++) write_word($urandom);
        saved_sent = sent_count;
        chk("pre_flush_level", 32'(fifo_level), 32'd3);
        flush = 1; wr_valid = 1; wr_data = $urandom; in_config_accept = 1;
        step();
        idle_inputs(); in_config_accept = 0;
        chk("flush_valid", 32'(in_config_valid), 32'd0);
        chk("flush_level", 32'(fifo_level), 32'd0);
        chk("flush_sent", 32'(sent_count), 32'(saved_sent));

        // ---------------- reset mid-drive ----------------
        for (int i = 0; i < 3; i++) write_word($urandom);
        reset = 1;
        #1;
        model_reset();
        chk("mid_rst_valid", 32'(in_config_valid), 32'd0);
        chk("mid_rst_data", in_config_data, 32'd0);
        chk("mid_rst_level", 32'(fifo_level), 32'd0);
        chk("mid_rst_sent", 32'(sent_count), 32'd0);
        @(posedge clk); #2;
        reset = 0;
        in_config_accept = 1;
        write_word(32'h1234_5678);
        step();
        chk("post_rst_data", in_config_data, 32'h1234_5678);
        step();
        chk("post_rst_sent", 32'(sent_count), 32'd1);

        // ---------------- streaming, pointer wrap ----------------
        saved_sent = sent_count;
        wr_valid = 1;
        for (int i = 0; i < 40; i++) begin
            wr_data = $urandom;
            step();
        end
        wr_valid = 0;
        step(); step(); step();
        chk("stream_sent", 32'(sent_count), 32'(saved_sent + 16'd40));

        // ---------------- randomized traffic ----------------
        for (int i = 0; i < 400; i++) begin
            wr_valid         = ($urandom_range(0, 3) != 0);
            wr_data          = $urandom;
            in_config_accept = ($urandom_range(0, 4) == 0);
            flush            = ($urandom_range(0, 40) == 0);
            err_clear        = ($urandom_range(0, 30) == 0);
            step();
        end
        idle_inputs();
        in_config_accept = 1;
        repeat (8) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
